// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, ZERO, FIN} state_t;

   state_t           state_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] rem_reg;
   logic [WIDTH-1:0] dvd_reg;   // dividend shifts out the top, quotient bits shift in below
   logic [WIDTH-1:0] dsr_reg;

   logic [WIDTH:0]   shift_next;
   logic [WIDTH:0]   diff_next;
   logic             qbit_next;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] dvd_next;
   logic [WIDTH-1:0] q_final;
   logic [WIDTH-1:0] r_final;
   logic [WIDTH-1:0] dvd_load;
   logic [WIDTH-1:0] dsr_load;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic neg_q_reg;
   logic neg_r_reg;
`endif

   // The shifted partial remainder is below 2*divisor, so the borrow bit alone decides the compare.
   always_comb begin
      shift_next = {rem_reg, dvd_reg[WIDTH-1]};
      diff_next  = shift_next - {1'b0, dsr_reg};
      qbit_next  = ~diff_next[WIDTH];
      rem_next   = qbit_next ? diff_next[WIDTH-1:0] : shift_next[WIDTH-1:0];
      dvd_next   = {dvd_reg[WIDTH-2:0], qbit_next};
   end

`ifdef SEQ_DIVIDER_SIGNED_EN
   always_comb begin
      q_final  = neg_q_reg ? -dvd_next : dvd_next;
      r_final  = neg_r_reg ? -rem_next : rem_next;
      dsr_load = divisor[WIDTH-1] ? -divisor : divisor;
      // Divide-by-zero reports the raw dividend, so keep it unconverted in that case.
      if (divisor == '0 || !dividend[WIDTH-1])
         dvd_load = dividend;
      else
         dvd_load = -dividend;
   end
`else
   always_comb begin
      q_final  = dvd_next;
      r_final  = rem_next;
      dvd_load = dividend;
      dsr_load = divisor;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         rem_reg     <= '0;
         dvd_reg     <= '0;
         dsr_reg     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         neg_q_reg   <= 1'b0;
         neg_r_reg   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE, FIN: begin
               if (start) begin
                  dvd_reg <= dvd_load;
                  dsr_reg <= dsr_load;
                  rem_reg <= '0;
                  cnt_reg <= '0;
                  busy    <= 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
                  neg_q_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  neg_r_reg <= dividend[WIDTH-1];
`endif
                  state_reg <= (divisor == '0) ? ZERO : RUN;
               end else begin
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            RUN: begin
               rem_reg <= rem_next;
               dvd_reg <= dvd_next;
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == CW'(WIDTH - 1)) begin
                  quotient    <= q_final;
                  remainder   <= r_final;
                  div_by_zero <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state_reg   <= FIN;
               end
            end
            ZERO: begin
               quotient    <= '1;
               remainder   <= dvd_reg;
               div_by_zero <= 1'b1;
               busy        <= 1'b0;
               done        <= 1'b1;
               state_reg   <= FIN;
            end
            default: begin
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=8): vector table plus back-to-back, ignored-start and reset sequences.
module tb_seq_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int tests = 0;
   int failed = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Called just after the accepting edge; returns at the negedge where done is seen.
   // inj >= 0 pulses start with unrelated operands for one cycle at that iteration.
   task automatic wait_done(input int inj, output int edges, output int bc);
      bit seen;
      edges = 0;
      bc    = 0;
      seen  = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 40 && !seen; i++) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy) bc++;
            if (edges == inj) begin
               dividend = 8'd100;
               divisor  = 8'd7;
               start    = 1'b1;
            end else if (edges == inj + 1) begin
               start = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
         end
      end
      if (!seen) edges = -1;
   endtask

   initial begin
      int edges;
      int bc;
`ifdef SEQ_DIVIDER_SIGNED_EN
      vecs[0] = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0};
      vecs[1] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0};
      vecs[2] = '{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0};
      vecs[3] = '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0};
      vecs[4] = '{8'hCE, 8'h00, 8'hFF, 8'hCE, 1'b1};
      vecs[5] = '{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0};
      vecs[6] = '{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0};
      vecs[7] = '{8'h0F, 8'h03, 8'h05, 8'h00, 1'b0};
      vecs[8] = '{8'h7F, 8'h01, 8'h7F, 8'h00, 1'b0};
      vecs[9] = '{8'h80, 8'h02, 8'hC0, 8'h00, 1'b0};
`else
      vecs[0] = '{8'd15,  8'd3,   8'd5,   8'd0,   1'b0};
      vecs[1] = '{8'd200, 8'd0,   8'hFF,  8'hC8,  1'b1};
      vecs[2] = '{8'd28,  8'd5,   8'd5,   8'd3,   1'b0};
      vecs[3] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
      vecs[4] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
      vecs[5] = '{8'd0,   8'd7,   8'd0,   8'd0,   1'b0};
      vecs[6] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
      vecs[7] = '{8'd200, 8'd13,  8'd15,  8'd5,   1'b0};
      vecs[8] = '{8'd1,   8'd0,   8'hFF,  8'd1,   1'b1};
      vecs[9] = '{8'd170, 8'd2,   8'd85,  8'd0,   1'b0};
`endif

      @(negedge clk);
      #1;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset quotient", quotient, 0);
      chk("reset remainder", remainder, 0);
      chk("reset dbz", div_by_zero, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].a, vecs[i].b);
         wait_done(-1, edges, bc);
         $display("[TB] vec %0d: 0x%02h / 0x%02h -> q=0x%02h r=0x%02h dbz=%0d after %0d edges",
                  i, vecs[i].a, vecs[i].b, quotient, remainder, div_by_zero, edges);
         chk($sformatf("vec%0d latency", i), edges, vecs[i].z ? 1 : W);
         chk($sformatf("vec%0d busy cycles", i), bc, vecs[i].z ? 1 : W);
         chk($sformatf("vec%0d quotient", i), quotient, vecs[i].q);
         chk($sformatf("vec%0d remainder", i), remainder, vecs[i].r);
         chk($sformatf("vec%0d dbz", i), div_by_zero, vecs[i].z);
         @(negedge clk);
         chk($sformatf("vec%0d done pulse width", i), done, 0);
         chk($sformatf("vec%0d results held", i), {quotient, remainder}, {vecs[i].q, vecs[i].r});
      end

      // Back-to-back: start held through FIN with new operands
      issue(8'd123, 8'd6);
      wait_done(-1, edges, bc);
      $display("[TB] b2b first: 123/6 -> q=%0d r=%0d", quotient, remainder);
      chk("b2b first latency", edges, W);
      chk("b2b first quotient", quotient, 20);
      chk("b2b first remainder", remainder, 3);
      dividend = 8'd255;
      divisor  = 8'd1;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(-1, edges, bc);
      $display("[TB] b2b second: 255/1 -> q=%0d r=%0d", quotient, remainder);
      chk("b2b second latency", edges, W);
      chk("b2b no idle gap", bc, W);
      chk("b2b second quotient", quotient, 255);
      chk("b2b second remainder", remainder, 0);

      // Divide-by-zero then a normal division clears the flag
      issue(8'd200, 8'd0);
      wait_done(-1, edges, bc);
      $display("[TB] dbz: 200/0 -> q=0x%02h r=0x%02h dbz=%0d", quotient, remainder, div_by_zero);
      chk("dbz latency", edges, 1);
      chk("dbz flag", div_by_zero, 1);
      issue(8'd9, 8'd2);
      wait_done(-1, edges, bc);
      $display("[TB] after dbz: 9/2 -> q=%0d r=%0d dbz=%0d", quotient, remainder, div_by_zero);
      chk("dbz cleared", div_by_zero, 0);
      chk("after dbz quotient", {quotient, remainder}, {8'd4, 8'd1});

      // start pulsed mid-RUN must be ignored
      issue(8'd15, 8'd3);
      wait_done(3, edges, bc);
      $display("[TB] ignored start: 15/3 -> q=%0d r=%0d after %0d edges", quotient, remainder, edges);
      chk("ignored start latency", edges, W);
      chk("ignored start quotient", quotient, 5);
      chk("ignored start remainder", remainder, 0);
      @(negedge clk);
      chk("ignored start no extra op", busy, 0);

      // Asynchronous reset in the middle of iteration 4
      issue(8'd99, 8'd4);
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      $display("[TB] mid-run reset: busy=%0d done=%0d q=%0d r=%0d dbz=%0d",
               busy, done, quotient, remainder, div_by_zero);
      chk("async reset busy", busy, 0);
      chk("async reset outputs", {done, quotient, remainder, div_by_zero}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bc = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) bc++;
      end
      chk("no done after reset", bc, 0);
      issue(8'd28, 8'd5);
      wait_done(-1, edges, bc);
      $display("[TB] post-reset: 28/5 -> q=%0d r=%0d", quotient, remainder);
      chk("post-reset latency", edges, W);
      chk("post-reset result", {quotient, remainder}, {8'd5, 8'd3});

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
